// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt timer controller.
// Channel index type, channel ceiling and the fixed IM1 vector.
package int_ctrl_pkg;
    localparam int MAX_CH = 8;
    typedef logic [2:0] ch_idx_t;
    localparam logic [7:0] DEF_VEC = 8'hFF;
endpackage

// File: rtl/int_timer_ch.sv
// One timer channel: period/enable registers, free-running counter, terminal-count pulse.
// Latency: tc is combinational from the counter; a load takes effect on the next edge.
// Backpressure: none; a load always wins over counting.
module int_timer_ch
    import int_ctrl_pkg::*;
#(
    parameter int CNT_W = 20,
    parameter logic [CNT_W-1:0] RST_PERIOD = '0,
    parameter bit RST_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_period,
    input  logic             load_en,
    output logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic             active;

    assign active = en_q && (period_q != '0);
    // A load clears the counter, so the cycle carrying it never counts as a wrap.
    assign tc     = active && !load && (cnt_q == period_q - CNT_W'(1));
    assign en     = en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= RST_PERIOD;
            en_q     <= RST_EN;
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= load_period;
            en_q     <= load_en;
            cnt_q    <= '0;
        end else if (!active || tc) begin
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/int_timer_ctrl.sv
// Multi-channel periodic interrupt source with fixed priority and Z80-style vector (INT_VEC_EN).
// Latency: pending one edge after terminal count, int_n one edge after pending; int_vec combinational.
// Backpressure: none; pending holds until acknowledged, a new terminal count beats a same-cycle ack.
module int_timer_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 20,
    parameter int DEF_PERIOD = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_en,
    input  logic              vec_we,
    input  logic [7:0]        vec_din,
    input  logic              int_ack,
    output logic              int_n,
    output logic [7:0]        int_vec,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_nxt;
    logic [NUM_CH-1:0] ack_mask;
    logic              any_pend;
    ch_idx_t           win_idx;
    logic              int_n_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        int_timer_ch #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (CNT_W'(DEF_PERIOD)),
            .RST_EN     (i == 0)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .load        (cfg_we && (cfg_ch == ch_idx_t'(i))),
            .load_period (cfg_period),
            .load_en     (cfg_en),
            .en          (ch_en[i]),
            .tc          (tc[i])
        );
    end

    // Scan from the top down so the lowest pending index is the last one written.
    always_comb begin
        win_idx  = '0;
        any_pend = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win_idx  = ch_idx_t'(i);
                any_pend = 1'b1;
            end
        end
        ack_mask    = (int_ack && any_pend) ? (NUM_CH'(1) << win_idx) : '0;
        pending_nxt = (pending_q & ~ack_mask) | tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            int_n_q   <= 1'b1;
        end else begin
            pending_q <= pending_nxt;
            int_n_q   <= ~|(pending_q & ch_en);
        end
    end

`ifdef INT_VEC_EN
    logic [7:0] vec_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_base <= 8'h00;
        end else if (vec_we) begin
            vec_base <= vec_din;
        end
    end

    assign int_vec = {vec_base[7:4], win_idx, 1'b0};
`else
    wire unused_vec = &{1'b0, vec_we, vec_din};

    assign int_vec = DEF_VEC;
`endif

    assign int_n   = int_n_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_int_timer_ctrl.sv
// Randomized and directed bench for int_timer_ctrl against a cycle-count based reference model.
module tb_int_timer_ctrl;

    localparam int NUM_CH     = 2;
    localparam int CNT_W      = 8;
    localparam int DEF_PERIOD = 10;
`ifdef INT_VEC_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_en;
    logic              vec_we;
    logic [7:0]        vec_din;
    logic              int_ack;
    logic              int_n;
    logic [7:0]        int_vec;
    logic [NUM_CH-1:0] pending;

    int checks   = 0;
    int failures = 0;

    int_timer_ctrl #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .vec_we     (vec_we),
        .vec_din    (vec_din),
        .int_ack    (int_ack),
        .int_n      (int_n),
        .int_vec    (int_vec),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [NUM_CH-1:0] p);
        for (int i = 0; i < NUM_CH; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic int exp_vec(input bit [NUM_CH-1:0] p, input bit [7:0] base);
        if (!VEC_EN) return 8'hFF;
        return (base & 8'hF0) + lowest(p) * 2;
    endfunction

    // Reference model: a channel's counter is (cycles since its last load or reset) mod period.
    int              m_per   [NUM_CH];
    bit              m_en    [NUM_CH];
    int              m_start [NUM_CH];
    int              m_cyc;
    bit [NUM_CH-1:0] m_pend;
    bit              m_int_n;
    bit [7:0]        m_base;
    bit              model_valid = 1'b0;
    bit [NUM_CH-1:0] m_tc;
    bit [NUM_CH-1:0] m_enb;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_per[i]   = DEF_PERIOD;
                m_en[i]    = (i == 0);
                m_start[i] = 0;
            end
            m_cyc       = 0;
            m_pend      = '0;
            m_int_n     = 1'b1;
            m_base      = 8'h00;
            model_valid = 1'b1;
        end else if (model_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_enb[i] = m_en[i];
                m_tc[i]  = m_en[i] && (m_per[i] != 0) && !(cfg_we && int'(cfg_ch) == i)
                           && ((m_cyc - m_start[i]) % m_per[i] == m_per[i] - 1);
            end
            m_int_n = ((m_pend & m_enb) == 0);
            if (int_ack && m_pend != 0) m_pend[lowest(m_pend)] = 1'b0;
            m_pend = m_pend | m_tc;
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                m_per[cfg_ch]   = int'(cfg_period);
                m_en[cfg_ch]    = cfg_en;
                m_start[cfg_ch] = m_cyc + 1;
            end
            if (vec_we) m_base = vec_din;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_pending", int'(pending), int'(m_pend));
            chk("model_int_n", int'(int_n), int'(m_int_n));
            chk("model_int_vec", int'(int_vec), exp_vec(m_pend, m_base));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        vec_we  = 1'b0;
        int_ack = 1'b0;
    endtask

    task automatic wcfg(input int ch, input int per, input bit en);
        cfg_we     = 1'b1;
        cfg_ch     = 3'(ch);
        cfg_period = CNT_W'(per);
        cfg_en     = en;
        cyc();
    endtask

    task automatic wait_pend(input bit [NUM_CH-1:0] mask, input string nm);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if ((pending & mask) == mask) hit = 1'b1;
            else cyc();
        end
        if (!hit) chk(nm, int'(pending), int'(mask));
    endtask

    // Counting from the cycle after reset release with the default 10-cycle period on ch0.
    task automatic check_def_period(input string tag);
        for (int k = 0; k < 9; k++) cyc();
        @(negedge clk);
        chk({tag, "_pend_c9"}, int'(pending), 0);
        cyc();
        @(negedge clk);
        chk({tag, "_pend_c10"}, int'(pending), 1);
        chk({tag, "_intn_c10"}, int'(int_n), 1);
        cyc();
        @(negedge clk);
        chk({tag, "_intn_c11"}, int'(int_n), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_en     = 1'b0;
        vec_we     = 1'b0;
        vec_din    = '0;
        int_ack    = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_pending", int'(pending), 0);
        chk("rst_int_n", int'(int_n), 1);
        chk("rst_int_vec", int'(int_vec), VEC_EN ? 8'h00 : 8'hFF);
        rst = 1'b0;
        check_def_period("first");

        // Freeze both channels pending, then walk through acknowledges.
        wcfg(1, 3, 1'b1);
        wait_pend(2'b11, "wait_both_pending");
        wcfg(0, 0, 1'b1);
        wcfg(1, 0, 1'b1);
        vec_we  = 1'b1;
        vec_din = 8'h40;
        cyc();
        @(negedge clk);
        chk("vec_both", int'(int_vec), VEC_EN ? 8'h40 : 8'hFF);
        chk("pend_both", int'(pending), 3);
        int_ack = 1'b1;
        cyc();
        @(negedge clk);
        chk("ack1_pend", int'(pending), 2);
        chk("ack1_vec", int'(int_vec), VEC_EN ? 8'h42 : 8'hFF);
        int_ack = 1'b1;
        cyc();
        @(negedge clk);
        chk("ack2_pend", int'(pending), 0);
        int_ack = 1'b1;
        cyc();
        @(negedge clk);
        chk("ack_none_pend", int'(pending), 0);
        chk("ack_none_vec", int'(int_vec), VEC_EN ? 8'h40 : 8'hFF);
        chk("ack_none_int_n", int'(int_n), 1);

        // Ack landing on the same cycle as a ch0 terminal count.
        wcfg(0, 4, 1'b1);
        wait_pend(2'b01, "wait_ch0_pending");
        cyc();
        cyc();
        cyc();
        int_ack = 1'b1;
        cyc();
        @(negedge clk);
        chk("ack_tc_pend0", int'(pending[0]), 1);
        chk("ack_tc_int_n", int'(int_n), 0);

        // Zero period never pends; an out-of-range channel write is dropped.
        wcfg(0, 0, 1'b0);
        int_ack = 1'b1;
        cyc();
        wcfg(5, 2, 1'b1);
        for (int k = 0; k < 100; k++) cyc();
        @(negedge clk);
        chk("idle100_pend", int'(pending), 0);
        chk("idle100_int_n", int'(int_n), 1);

        // Reset with both pending discards everything and restores the default period.
        wcfg(0, 2, 1'b1);
        wcfg(1, 3, 1'b1);
        wait_pend(2'b11, "wait_both_again");
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("midrst_pend", int'(pending), 0);
        chk("midrst_int_n", int'(int_n), 1);
        rst = 1'b0;
        check_def_period("after_rst");

        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 299) == 0);
            cfg_we     = ($urandom_range(0, 11) == 0);
            cfg_ch     = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            cfg_period = CNT_W'($urandom_range(0, 12));
            cfg_en     = ($urandom_range(0, 3) != 0);
            vec_we     = ($urandom_range(0, 19) == 0);
            vec_din    = 8'($urandom);
            int_ack    = ($urandom_range(0, 4) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
